// File: rtl/write_buffer.sv
// ---------------------------------------------------------------------------
// write_buffer
//
// FIFO write buffer between the cache's backing-memory port and main memory.
// Eviction words from the cache are absorbed into a small circular buffer.
// They are drained to memory one word per cycle whenever the cache is not
// issuing a fill read. Fill reads are serviced straight from memory, but any
// buffered word for the same address overrides the memory data. This way a
// line that is evicted and then re-fetched returns the newest data.
//
// Parameters:
//   DEPTH      number of buffered word entries (power of two, >= 2)
//
// Optional build macro:
//   WRITE_BUFFER_COALESCE_EN  when defined, a write to an address already
//                             buffered (other than the head being drained this
//                             cycle) overwrites that entry in place instead of
//                             appending a new one.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   up_addr    byte address from the cache (read or write), word aligned
//   up_wdata   eviction write data
//   up_write   write request from the cache
//   up_read    fill read request from the cache
//   up_rdata   read data to the cache (combinational)
//   up_stall   write not accepted this cycle (combinational)
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_write  memory write enable
//   mem_rdata  memory read data (combinational from mem_addr)
//   count      number of valid entries
//   empty      count == 0
//   full       count == DEPTH
// ---------------------------------------------------------------------------
module write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              up_addr,
    input  logic [31:0]              up_wdata,
    input  logic                     up_write,
    input  logic                     up_read,
    output logic [31:0]              up_rdata,
    output logic                     up_stall,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_write,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [29:0]      r_addr  [DEPTH];
    logic [31:0]      r_data  [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_append;
    logic             w_fwdHit;
    logic [31:0]      w_fwdData;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;

    // Draining only happens when the cache leaves the memory port free.
    assign w_pop = !empty && !up_read;

    // Forwarding: scan from oldest to youngest so that the last match seen
    // is the youngest copy of the word.
    always_comb begin
        w_fwdHit  = 1'b0;
        w_fwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[r_head + PTR_W'(i)] &&
                r_addr[r_head + PTR_W'(i)] == up_addr[31:2]) begin
                w_fwdHit  = 1'b1;
                w_fwdData = r_data[r_head + PTR_W'(i)];
            end
        end
    end

`ifdef WRITE_BUFFER_COALESCE_EN
    logic             w_coalHit;
    logic [PTR_W-1:0] w_coalIdx;

    // A matching entry may absorb the write, except for the head that is
    // leaving for memory this very cycle; that word would otherwise be lost.
    always_comb begin
        w_coalHit = 1'b0;
        w_coalIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[r_head + PTR_W'(i)] &&
                r_addr[r_head + PTR_W'(i)] == up_addr[31:2] &&
                !(w_pop && (r_head + PTR_W'(i)) == r_head)) begin
                w_coalHit = 1'b1;
                w_coalIdx = r_head + PTR_W'(i);
            end
        end
    end

    assign up_stall = up_write && full && up_read && !w_coalHit;
    assign w_push   = up_write && !up_stall;
    assign w_append = w_push && !w_coalHit;
`else
    // When full without a read, the same-cycle pop frees the slot being written.
    assign up_stall = up_write && full && up_read;
    assign w_push   = up_write && !up_stall;
    assign w_append = w_push;
`endif

    // Memory port: the drain owns it when popping, otherwise the cache address
    // passes straight through for reads.
    always_comb begin
        mem_write = w_pop;
        mem_addr  = up_addr;
        mem_wdata = '0;
        if (w_pop) begin
            mem_addr  = {r_addr[r_head], 2'b00};
            mem_wdata = r_data[r_head];
        end
    end

    assign up_rdata = (up_read && w_fwdHit) ? w_fwdData : mem_rdata;

    // Buffer state. The pop invalidation is written before the append so that
    // when full, the slot freed by the head is refilled in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
`ifdef WRITE_BUFFER_COALESCE_EN
            if (w_push && w_coalHit) begin
                r_data[w_coalIdx] <= up_wdata;
            end
`endif
            if (w_append) begin
                r_addr[r_tail]  <= up_addr[31:2];
                r_data[r_tail]  <= up_wdata;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_append && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_append && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- FIFO write buffer between the cache's backing-memory port and main memory.
- Absorbs eviction (write-back) words from the cache and drains them to memory on cycles when the cache is not reading.
- Forwards buffered data to cache fill reads, so a line evicted and then re-fetched returns the new data.
- Memory is single-port: synchronous write, combinational read.

Parameters:
- DEPTH, 4, number of buffered word entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- up_addr  input  32  byte address from the cache (read or write); word-aligned.
- up_wdata  input  32  eviction write data.
- up_write  input  1  write request from the cache.
- up_read  input  1  fill read request from the cache.
- up_rdata  output  32  read data to the cache; combinational.
- up_stall  output  1  write not accepted this cycle; combinational.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_write  output  1  memory write enable; memory writes on the rising edge.
- mem_rdata  input  32  memory read data; combinational from mem_addr.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset: head=0, tail=0, count=0, all entries invalid; empty=1, full=0, up_stall=0, mem_write=0. Entry addr/data registers are cleared to 0.
- Reset asserted mid-operation discards buffered writes. Intentional: the processor reset reinitialises memory state.
- Storage: DEPTH entries of {addr[31:2], data[31:0]}; circular head/tail pointers, wrap modulo DEPTH.
- Drain (pop) condition: !empty && !up_read.
  - When it holds: mem_write=1, mem_addr={head.addr,2'b00}, mem_wdata=head.data.
  - At the rising edge: head advances by 1 and the entry is invalidated.
  - Drain rate: one word per cycle.
- Read condition: up_read=1.
  - mem_addr=up_addr, mem_write=0.
  - up_rdata = data of the youngest valid entry whose addr equals up_addr[31:2], else mem_rdata.
  - Youngest means the entry closest to tail-1.
- Idle (up_read=0, empty): mem_addr=up_addr, mem_wdata=0, mem_write=0, up_rdata=mem_rdata.
- Push condition: up_write && !up_stall. At the rising edge, {up_addr[31:2], up_wdata} is written at tail and tail advances.
- up_stall = up_write && full && up_read.
  - When full with no read, the same-cycle pop frees a slot and the push is accepted.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Simultaneous up_read and up_write:
  - Both are serviced: the push is accepted if not stalled, and the read forwards.
  - Forwarding uses pre-edge buffer state, so the word being written in the same cycle is not forwarded.
- Ordering: memory receives writes in acceptance order. Duplicate addresses are written in order, so the last write wins in memory.
- No combinational path from mem_rdata to up_stall or mem_write.

Optional Feature:
- Macro: WRITE_BUFFER_COALESCE_EN.
- Defined:
  - On push, if a valid entry matches up_addr[31:2] and is not the head being popped this cycle, its data is overwritten in place.
  - In that case tail and count are unchanged. This includes the full state, where the write is accepted without stall.
  - If the only match is the head being popped this cycle, the write appends normally.
  - up_stall is only asserted when no coalescable match exists.
- Undefined: every accepted write appends a new entry, as described in Behaviour.

Test Plan:
- Reset mid-drain with count=3 -> next cycle count=0, empty=1, mem_write=0, up_stall=0.
- Push 0x100=0xAAAA0001, 0x104=0xAAAA0002 with up_read held high for 2 cycles, then release -> count=2 while held. After release, mem_write on 2 consecutive cycles: 0x100 first, then 0x104; then empty=1.
- Push 0x200=0x11111111, hold up_read=1, read 0x200 -> up_rdata=0x11111111 with mem_rdata=0xDEADBEEF. Read 0x204 -> up_rdata=0xDEADBEEF. Read 0x202 (same word) -> 0x11111111.
- Two pushes to 0x300 (0x1, then 0x2) with reads held, then read 0x300 -> up_rdata=0x2 (youngest). Without coalescing, count=2 and the drain order is 0x1 then 0x2.
- Fill DEPTH=4 entries with up_read=1, then up_write+up_read -> up_stall=1, count stays 4. Drop up_read with up_write still high -> push and pop in the same cycle, count stays 4. Wrap-around drain order is preserved.
- With WRITE_BUFFER_COALESCE_EN: full buffer, up_read=1, write an address already buffered -> up_stall=0, count=4, and a subsequent forward returns the new data.
